fetch_unit: RTL and testbench

Instruction fetch stage of the segmented ARMv8 (LEGv8-subset) pipeline, and the producer of the opcode field consumed by CU. Holds the PC and issues word addresses to a synchronous instruction memory with 1-cycle read latency. Captures returned words into the IF/ID pipeline register and presents instr[31:21] as the 11-bit opcode for the decode stage. Supports hazard stalls and branch redirect/flush.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/if_id_reg.sv | 57 +++++
 rtl/fetch_unit.sv | 137 +++++++++++++
 tb/tb_fetch_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared pipeline constants for the LEGv8-subset core: word/opcode widths,
// PC step, the opcode values decoded by CU, and the fetch-stage action type.
package cpu_pkg;

   localparam int INSTR_W  = 32;
   localparam int OPCODE_W = 11;
   localparam int PC_INC   = 4;

   localparam logic [OPCODE_W-1:0] OP_ADD  = 11'b10001011000;
   localparam logic [OPCODE_W-1:0] OP_SUB  = 11'b11001011000;
   localparam logic [OPCODE_W-1:0] OP_AND  = 11'b10001010000;
   localparam logic [OPCODE_W-1:0] OP_ORR  = 11'b10101010000;
   localparam logic [OPCODE_W-1:0] OP_STUR = 11'b11111000000;
   localparam logic [OPCODE_W-1:0] OP_LDUR = 11'b11111000010;

   // What the fetch stage does on the coming edge.
   typedef enum logic [1:0] {
      ACT_RUN,
      ACT_STALL,
      ACT_BRANCH
   } fetch_act_e;

   // A redirect always beats a hazard hold: the held instruction is on the
   // wrong path anyway.
   function automatic fetch_act_e decode_act(input logic stall, input logic branch_taken);
      if (branch_taken) return ACT_BRANCH;
      if (stall)        return ACT_STALL;
      return ACT_RUN;
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: valid bit, instruction address and instruction
// word. Flush clears only the valid bit; pc/instr are retained.
module if_id_reg
   import cpu_pkg::*;
#(
   parameter int PC_W = 64
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic               flush,
   input  logic               valid_in,
   input  logic [PC_W-1:0]    pc_in,
   input  logic [INSTR_W-1:0] instr_in,
   output logic               valid,
   output logic [PC_W-1:0]    pc,
   output logic [INSTR_W-1:0] instr
);

   logic               valid_d, valid_q;
   logic [PC_W-1:0]    pc_d, pc_q;
   logic [INSTR_W-1:0] instr_d, instr_q;

   // Next-state select: flush wins over load, otherwise hold.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      valid_d = valid_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (load) begin
         valid_d = valid_in;
         pc_d    = pc_in;
         instr_d = instr_in;
      end
   end

   // Register with asynchronous clear.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
      if (reset) begin
         valid_q <= 1'b0;
         pc_q    <= '0;
         instr_q <= '0;
      end else begin
         valid_q <= valid_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

   assign valid = valid_q;
   assign pc    = pc_q;
   assign instr = instr_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives a 1-cycle-latency synchronous
// instruction memory, and fills IF/ID. Handles hazard stalls and branch
// redirects (redirect squashes the in-flight word and the IF/ID slot).
// Optional build macro FETCH_PERF_CNT_EN adds saturating fetch/stall counters.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int              PC_W     = 64,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                stall,
   input  logic                branch_taken,
   input  logic [PC_W-1:0]     branch_target,
   output logic [PC_W-1:0]     imem_addr,
   input  logic [INSTR_W-1:0]  imem_rdata,
   output logic                if_id_valid,
   output logic [PC_W-1:0]     if_id_pc,
   output logic [INSTR_W-1:0]  if_id_instr,
   output logic [OPCODE_W-1:0] if_id_opcode
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]         perf_fetched,
   output logic [31:0]         perf_stalls
`endif
);

   localparam logic [PC_W-1:0] PC_STEP = PC_W'(PC_INC);

   fetch_act_e      act;
   logic [PC_W-1:0] target_aligned;
   logic [PC_W-1:0] pc_d, pc_q;
   logic [PC_W-1:0] req_pc_d, req_pc_q;
   logic            req_valid_d, req_valid_q;

   // Branch targets are word addresses; the byte-offset bits carry no meaning.
   logic unused_target_lsbs;
   assign unused_target_lsbs = ^branch_target[1:0];

   assign act            = decode_act(stall, branch_taken);
   assign target_aligned = {branch_target[PC_W-1:2], 2'b00};

   // Memory address: redirect target, else re-issue of the held request so the
   // returned word still matches req_pc, else the next sequential PC.
   always_comb begin
      imem_addr = pc_q;
      unique case (act)
         ACT_BRANCH: imem_addr = target_aligned;
         ACT_STALL:  imem_addr = req_pc_q;
         default:    imem_addr = pc_q;
      endcase
   end

   // PC and in-flight request next state.
   always_comb begin
      pc_d        = pc_q;
      req_pc_d    = req_pc_q;
      req_valid_d = req_valid_q;
      unique case (act)
         ACT_RUN: begin
            req_pc_d    = pc_q;
            req_valid_d = 1'b1;
            pc_d        = pc_q + PC_STEP;
         end
         ACT_BRANCH: begin
            req_pc_d    = target_aligned;
            req_valid_d = 1'b1;
            pc_d        = target_aligned + PC_STEP;
         end
         default: ;
      endcase
   end

   // PC and request registers; reset drops anything in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q        <= RESET_PC;
         req_pc_q    <= '0;
         req_valid_q <= 1'b0;
      end else begin
         pc_q        <= pc_d;
         req_pc_q    <= req_pc_d;
         req_valid_q <= req_valid_d;
      end
   end

   if_id_reg #(
      .PC_W     (PC_W)
   ) u_if_id (
      .clk      (clk),
      .reset    (reset),
      .load     (act == ACT_RUN),
      .flush    (act == ACT_BRANCH),
      .valid_in (req_valid_q),
      .pc_in    (req_pc_q),
      .instr_in (imem_rdata),
      .valid    (if_id_valid),
      .pc       (if_id_pc),
      .instr    (if_id_instr)
   );

   // CU must see no control activity from a bubble.
   assign if_id_opcode = if_id_valid ? if_id_instr[INSTR_W-1 -: OPCODE_W] : '0;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetched_d, fetched_q;
   logic [31:0] stalls_d, stalls_q;

   // Saturating event counters: live IF/ID loads and hazard-hold cycles.
   always_comb begin
      fetched_d = fetched_q;
      stalls_d  = stalls_q;
      if (act == ACT_RUN && req_valid_q && fetched_q != '1) begin
         fetched_d = fetched_q + 32'd1;
      end
      if (act == ACT_STALL && stalls_q != '1) begin
         stalls_d = stalls_q + 32'd1;
      end
   end

   // Counter registers, cleared by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetched_q <= '0;
         stalls_q  <= '0;
      end else begin
         fetched_q <= fetched_d;
         stalls_q  <= stalls_d;
      end
   end

   assign perf_fetched = fetched_q;
   assign perf_stalls  = stalls_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a registered memory model, a stream-level reference
// (fetch stream = consecutive words from the last redirect, one-slot pipe fill
// after reset or... delivered one per unstalled edge), a per-edge expected
// queue, and a negedge monitor that pops and compares.
module tb_fetch_unit;
   import cpu_pkg::*;

   localparam int PC_W = 64;
   localparam logic [PC_W-1:0] RESET_PC = 64'h0;

   logic              clk;
   logic              reset;
   logic              stall;
   logic              branch_taken;
   logic [PC_W-1:0]   branch_target;
   logic [PC_W-1:0]   imem_addr;
   logic [31:0]       imem_rdata;
   logic              if_id_valid;
   logic [PC_W-1:0]   if_id_pc;
   logic [31:0]       if_id_instr;
   logic [10:0]       if_id_opcode;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0]       perf_fetched;
   logic [31:0]       perf_stalls;
`endif

   fetch_unit #(
      .PC_W          (PC_W),
      .RESET_PC      (RESET_PC)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .if_id_valid   (if_id_valid),
      .if_id_pc      (if_id_pc),
      .if_id_instr   (if_id_instr),
      .if_id_opcode  (if_id_opcode)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetched  (perf_fetched),
      .perf_stalls   (perf_stalls)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Program image: words 0..5 carry the CU opcode list, the rest are an address hash.
   function automatic logic [31:0] mem_word(input logic [63:0] addr);
      logic [10:0] ops [6];
      logic [63:0] idx;
      ops = '{OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_STUR, OP_LDUR};
      idx = addr >> 2;
      if (idx < 64'd6) return {ops[idx[2:0]], 21'b0};
      return (addr[31:0] * 32'h9E3779B1) ^ addr[63:32] ^ 32'h5A5A_0F0F;
   endfunction

   // Synchronous instruction memory, one cycle of read latency.
   initial imem_rdata = 32'h0;
   always @(posedge clk) imem_rdata <= mem_word(imem_addr);

   // Reference model state (stream level).
   typedef struct {
      bit          valid;
      logic [63:0] pc;
   } rec_t;

   rec_t        exp_q[$];
   rec_t        last_rec;
   logic [63:0] s_pc;        // next address the stream will deliver
   bit          fill;        // pipe is still empty: next unstalled edge only issues
   int          m_fetched;
   int          m_stalls;

   task automatic model_reset();
      s_pc      = RESET_PC;
      fill      = 1'b1;
      last_rec  = '{valid: 1'b0, pc: 64'h0};
      m_fetched = 0;
      m_stalls  = 0;
   endtask

   // One cycle: drive inputs (at posedge+2), check the issued address, take the
   // edge, then push what IF/ID must show after it. Returns at posedge+2.
   task automatic step(input bit st, input bit br, input logic [63:0] tgt);
      logic [63:0] exp_addr;
      rec_t        r;
      stall         = st;
      branch_taken  = br;
      branch_target = tgt;
      #1;
      if (br)        exp_addr = tgt & ~64'h3;
      else if (st)   exp_addr = fill ? 64'h0 : s_pc;
      else           exp_addr = fill ? s_pc : s_pc + 64'd4;
      check("imem_addr", imem_addr, exp_addr);
      @(posedge clk);
      if (br) begin
         s_pc = tgt & ~64'h3;
         fill = 1'b0;
         r    = '{valid: 1'b0, pc: last_rec.pc};
      end else if (st) begin
         r = last_rec;
         m_stalls++;
      end else if (fill) begin
         fill = 1'b0;
         r    = '{valid: 1'b0, pc: last_rec.pc};
      end else begin
         r    = '{valid: 1'b1, pc: s_pc};
         s_pc = s_pc + 64'd4;
         m_fetched++;
      end
      exp_q.push_back(r);
      last_rec = r;
      #2;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 64'h0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " if_id_valid"},  {63'h0, if_id_valid}, 64'h0);
      check({tag, " if_id_pc"},     if_id_pc, 64'h0);
      check({tag, " if_id_instr"},  {32'h0, if_id_instr}, 64'h0);
      check({tag, " if_id_opcode"}, {53'h0, if_id_opcode}, 64'h0);
      check({tag, " imem_addr"},    imem_addr, RESET_PC);
   endtask

   // Monitor: compare IF/ID against the expectation recorded for the last edge.
   always @(negedge clk) begin
      rec_t        r;
      logic [31:0] w;
      if (exp_q.size() > 0) begin
         r = exp_q.pop_front();
         check("if_id_valid", {63'h0, if_id_valid}, {63'h0, r.valid});
         if (r.valid) begin
            w = mem_word(r.pc);
            check("if_id_pc",     if_id_pc, r.pc);
            check("if_id_instr",  {32'h0, if_id_instr}, {32'h0, w});
            check("if_id_opcode", {53'h0, if_id_opcode}, {53'h0, w[31:21]});
         end else begin
            check("if_id_opcode bubble", {53'h0, if_id_opcode}, 64'h0);
         end
      end
   end

   // Run-time bound.
   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset         = 1'b1;
      stall         = 1'b0;
      branch_taken  = 1'b0;
      branch_target = 64'h0;
      model_reset();
      #1;
      check_reset_outputs("por");
      @(posedge clk);
      @(posedge clk);
      #2;
      reset = 1'b0;

      // Opcode list at 0..20, with a 3-cycle stall while IF/ID holds pc=8.
      run(4);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 64'h0);
      run(3);

      // Redirect to an unaligned target.
      step(1'b0, 1'b1, 64'h43);
      run(3);

      // Redirect together with stall: redirect wins.
      step(1'b1, 1'b1, 64'h100);
      run(3);

      // Sequential wrap through the top of the address space.
      step(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB);
      run(4);

      // Random mix of run, stall and redirect.
      for (int i = 0; i < 400; i++) begin
         bit          st, br;
         logic [63:0] tgt;
         st  = ($urandom % 4) == 0;
         br  = ($urandom % 12) == 0;
         tgt = ($urandom % 8 == 0) ? {32'hFFFF_FFFF, $urandom} : 64'($urandom_range(0, 1023));
         step(st, br, tgt);
      end

      // Asynchronous reset between edges: outputs clear with no clock.
      stall        = 1'b0;
      branch_taken = 1'b0;
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      check_reset_outputs("async");
      exp_q.delete();
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #2;
      reset = 1'b0;

      // Restart from RESET_PC: 10 fetches, 3 stall cycles, 1 redirect.
      run(6);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 64'h0);
      step(1'b0, 1'b1, 64'h200);
      run(5);

      @(negedge clk);
      #1;
`ifdef FETCH_PERF_CNT_EN
      check("perf_fetched", {32'h0, perf_fetched}, 64'(m_fetched));
      check("perf_stalls",  {32'h0, perf_stalls},  64'(m_stalls));
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
